// File: rtl/alfa_ext_pkg.sv
// Shared types and widths for the ALFA extension point server.
package alfa_ext_pkg;

  localparam int ID_W     = 19;
  localparam int COORD_W  = 16;
  localparam int CUSTOM_W = 16;

  // Top-level sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One point-cloud entry as it travels between the host, the RAM and the extension.
  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  z;
    logic [CUSTOM_W-1:0] custom;
  } point_t;

  // An extension ID is legal only below the point-cloud size latched for the run.
  function automatic logic id_in_range(input logic [ID_W-1:0] id,
                                       input logic [ID_W-1:0] size);
    return id < size;
  endfunction

endpackage

// File: rtl/ext_point_server_if.sv
// Extension-side bus between the point server (slave) and an extension module (master).
interface ext_point_server_if;
  import alfa_ext_pkg::*;

  logic                EXT_enable;
  logic [ID_W-1:0]     EXT_PCSize;
  logic                EXT_readReady;
  logic [ID_W-1:0]     EXT_readID;
  logic                EXT_readValid;
  logic [COORD_W-1:0]  EXT_pointX;
  logic [COORD_W-1:0]  EXT_pointY;
  logic [COORD_W-1:0]  EXT_pointZ;
  logic [CUSTOM_W-1:0] EXT_readCustomField;
  logic                EXT_writeValid;
  logic [ID_W-1:0]     EXT_writeID;
  logic [CUSTOM_W-1:0] EXT_writeCustomField;
  logic                EXT_writeReady;
  logic                EXT_doneProcessing;

  // Extension module: issues read/write requests and signals completion.
  modport master (
    input  EXT_enable, EXT_PCSize, EXT_readValid, EXT_pointX, EXT_pointY, EXT_pointZ,
           EXT_readCustomField, EXT_writeReady,
    output EXT_readReady, EXT_readID, EXT_writeValid, EXT_writeID, EXT_writeCustomField,
           EXT_doneProcessing
  );

  // Point server: answers requests from the point RAM.
  modport slave (
    output EXT_enable, EXT_PCSize, EXT_readValid, EXT_pointX, EXT_pointY, EXT_pointZ,
           EXT_readCustomField, EXT_writeReady,
    input  EXT_readReady, EXT_readID, EXT_writeValid, EXT_writeID, EXT_writeCustomField,
           EXT_doneProcessing
  );

endinterface

// File: rtl/ext_point_ram.sv
// Point RAM: coordinates and custom field stored in separate arrays so the custom
// field can be rewritten without touching the coordinates. Port A writes, port B
// reads with one cycle of latency.
module ext_point_ram
  import alfa_ext_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     a_we_coord,
  input  logic                     a_we_custom,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  point_t                   a_wdata,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output point_t                   b_rdata
);

  logic [3*COORD_W-1:0] coord_mem  [DEPTH];
  logic [CUSTOM_W-1:0]  custom_mem [DEPTH];
  logic [3*COORD_W-1:0] coord_q;
  logic [CUSTOM_W-1:0]  custom_q;

  // Lane-enabled writes on port A and registered reads on port B.
  // NOTE: the arrays and read registers take no reset so they map onto RAM macros;
  // point data therefore survives a block reset.
  always_ff @(posedge clk) begin
    if (a_we_coord) begin
      coord_mem[a_addr] <= {a_wdata.x, a_wdata.y, a_wdata.z};
    end
    if (a_we_custom) begin
      custom_mem[a_addr] <= a_wdata.custom;
    end
    coord_q  <= coord_mem[b_addr];
    custom_q <= custom_mem[b_addr];
  end

  assign b_rdata = {coord_q, custom_q};

endmodule

// File: rtl/ext_point_server.sv
// Core-side responder for the ALFA extension interface. Holds a point cloud loaded
// by the host, serves extension reads and custom-field writes during a run, and
// offers custom-field readback to the host while idle.
module ext_point_server
  import alfa_ext_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic                i_SYSTEM_clk,
  input  logic                i_SYSTEM_rst,
  input  logic                i_load_valid,
  output logic                o_load_ready,
  input  logic [COORD_W-1:0]  i_load_x,
  input  logic [COORD_W-1:0]  i_load_y,
  input  logic [COORD_W-1:0]  i_load_z,
  input  logic [CUSTOM_W-1:0] i_load_custom,
  input  logic                i_clear,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  input  logic [ID_W-1:0]     i_rd_addr,
  output logic [CUSTOM_W-1:0] o_rd_custom,
  output logic                o_error,
  output logic [ID_W-1:0]     o_reads_served,
  output logic [ID_W-1:0]     o_writes_accepted,
  ext_point_server_if.slave   ext
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [ID_W-1:0] DEPTH_ID = ID_W'(DEPTH);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       load_cnt_q, load_cnt_d;
  logic [ID_W-1:0]       pcsize_q, pcsize_d;
  logic [ID_W-1:0]       reads_q, reads_d;
  logic [ID_W-1:0]       writes_q, writes_d;
  logic                  error_q, error_d;
  logic                  host_rd_q, host_rd_d;
  // Read responder
  logic                  rd_armed_q, rd_armed_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_oob_q, rd_oob_d;
  logic                  rd_valid_q, rd_valid_d;
  point_t                rd_point_q, rd_point_d;
  // Write responder
  logic                  wr_armed_q, wr_armed_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  wr_oob_q, wr_oob_d;
  logic [AW-1:0]         wr_id_q, wr_id_d;
  logic [CUSTOM_W-1:0]   wr_data_q, wr_data_d;
  // RAM ports
  logic                  ram_we_coord, ram_we_custom;
  logic [AW-1:0]         ram_a_addr, ram_b_addr;
  point_t                ram_wdata, ram_rdata;
  logic                  rd_start, wr_start;

  ext_point_ram #(.DEPTH(DEPTH)) u_ram (
    .clk         (i_SYSTEM_clk),
    .a_we_coord  (ram_we_coord & i_SYSTEM_rst),
    .a_we_custom (ram_we_custom & i_SYSTEM_rst),
    .a_addr      (ram_a_addr),
    .a_wdata     (ram_wdata),
    .b_addr      (ram_b_addr),
    .b_rdata     (ram_rdata)
  );

  // Next-state, responder and RAM-port arbitration logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    pcsize_d      = pcsize_q;
    reads_d       = reads_q;
    writes_d      = writes_q;
    error_d       = error_q;
    host_rd_d     = 1'b0;
    rd_armed_d    = rd_armed_q;
    rd_pend_d     = 1'b0;
    rd_oob_d      = rd_oob_q;
    rd_valid_d    = rd_valid_q;
    rd_point_d    = rd_point_q;
    wr_armed_d    = wr_armed_q;
    wr_ready_d    = 1'b0;
    wr_oob_d      = wr_oob_q;
    wr_id_d       = wr_id_q;
    wr_data_d     = wr_data_q;
    ram_we_coord  = 1'b0;
    ram_we_custom = 1'b0;
    ram_a_addr    = load_cnt_q[AW-1:0];
    ram_wdata     = {i_load_x, i_load_y, i_load_z, i_load_custom};
    ram_b_addr    = i_rd_addr[AW-1:0];
    rd_start      = 1'b0;
    wr_start      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        host_rd_d = (i_rd_addr < DEPTH_ID);
        if (i_clear) begin
          load_cnt_d = '0;
          error_d    = 1'b0;
        end else begin
          if (i_load_valid) begin
            if (load_cnt_q < DEPTH_ID) begin
              ram_we_coord  = 1'b1;
              ram_we_custom = 1'b1;
              load_cnt_d    = load_cnt_q + ID_W'(1);
            end else begin
              error_d = 1'b1;
            end
          end
          if (i_start) begin
            state_d    = ST_RUN;
            pcsize_d   = load_cnt_q;
            reads_d    = '0;
            writes_d   = '0;
            rd_armed_d = 1'b1;
            rd_valid_d = 1'b0;
            wr_armed_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // Read request: sample ID, launch the RAM read, wait for readReady to drop.
        ram_b_addr = ext.EXT_readID[AW-1:0];
        rd_start   = rd_armed_q && ext.EXT_readReady && !ext.EXT_doneProcessing;
        if (rd_start) begin
          rd_pend_d  = 1'b1;
          rd_armed_d = 1'b0;
          rd_oob_d   = !id_in_range(ext.EXT_readID, pcsize_q);
          if (!id_in_range(ext.EXT_readID, pcsize_q)) error_d = 1'b1;
        end else if (!rd_armed_q && !ext.EXT_readReady && !rd_pend_q && !rd_valid_q) begin
          rd_armed_d = 1'b1;
        end
        if (rd_pend_q) begin
          rd_valid_d = 1'b1;
          rd_point_d = rd_oob_q ? '0 : ram_rdata;
        end else if (rd_valid_q && ext.EXT_readReady) begin
          rd_valid_d = 1'b0;
          reads_d    = reads_q + ID_W'(1);
        end

        // Write request: one-cycle writeReady pulse, then wait for writeValid to drop.
        wr_start = wr_armed_q && ext.EXT_writeValid && !ext.EXT_doneProcessing;
        if (wr_start) begin
          wr_ready_d = 1'b1;
          wr_armed_d = 1'b0;
          wr_id_d    = ext.EXT_writeID[AW-1:0];
          wr_data_d  = ext.EXT_writeCustomField;
          wr_oob_d   = !id_in_range(ext.EXT_writeID, pcsize_q);
          if (!id_in_range(ext.EXT_writeID, pcsize_q)) error_d = 1'b1;
        end else if (!wr_armed_q && !ext.EXT_writeValid) begin
          wr_armed_d = 1'b1;
        end
        if (wr_ready_q) begin
          writes_d = writes_q + ID_W'(1);
          if (!wr_oob_q) begin
            ram_we_custom    = 1'b1;
            ram_a_addr       = wr_id_q;
            ram_wdata.custom = wr_data_q;
          end
        end

        // Completion aborts any read still in flight; a write pulse this cycle lands.
        if (ext.EXT_doneProcessing) begin
          state_d    = ST_DONE;
          rd_pend_d  = 1'b0;
          rd_valid_d = 1'b0;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; RAM contents are untouched.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_SYSTEM_clk) begin
    if (!i_SYSTEM_rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      pcsize_q   <= '0;
      reads_q    <= '0;
      writes_q   <= '0;
      error_q    <= 1'b0;
      host_rd_q  <= 1'b0;
      rd_armed_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_point_q <= '0;
      wr_armed_q <= 1'b0;
      wr_ready_q <= 1'b0;
      wr_oob_q   <= 1'b0;
      wr_id_q    <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      pcsize_q   <= pcsize_d;
      reads_q    <= reads_d;
      writes_q   <= writes_d;
      error_q    <= error_d;
      host_rd_q  <= host_rd_d;
      rd_armed_q <= rd_armed_d;
      rd_pend_q  <= rd_pend_d;
      rd_oob_q   <= rd_oob_d;
      rd_valid_q <= rd_valid_d;
      rd_point_q <= rd_point_d;
      wr_armed_q <= wr_armed_d;
      wr_ready_q <= wr_ready_d;
      wr_oob_q   <= wr_oob_d;
      wr_id_q    <= wr_id_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_load_ready      = (state_q == ST_IDLE) && (load_cnt_q < DEPTH_ID);
  assign o_busy            = (state_q != ST_IDLE);
  assign o_done            = (state_q == ST_DONE);
  assign o_rd_custom       = host_rd_q ? ram_rdata.custom : '0;
  assign o_error           = error_q;
  assign o_reads_served    = reads_q;
  assign o_writes_accepted = writes_q;

  assign ext.EXT_enable          = (state_q == ST_RUN);
  assign ext.EXT_PCSize          = pcsize_q;
  assign ext.EXT_readValid       = rd_valid_q;
  assign ext.EXT_pointX          = rd_point_q.x;
  assign ext.EXT_pointY          = rd_point_q.y;
  assign ext.EXT_pointZ          = rd_point_q.z;
  assign ext.EXT_readCustomField = rd_point_q.custom;
  assign ext.EXT_writeReady      = wr_ready_q;

endmodule

// File: tb/tb_ext_point_server.sv
// Directed bench for ext_point_server: load, run with reads/writes, readback,
// error handling, load overflow and reset during a run.
module tb_ext_point_server;
  import alfa_ext_pkg::*;

  localparam int DEPTH = 2048;

  logic                i_SYSTEM_clk = 1'b0;
  logic                i_SYSTEM_rst;
  logic                i_load_valid;
  logic                o_load_ready;
  logic [COORD_W-1:0]  i_load_x, i_load_y, i_load_z;
  logic [CUSTOM_W-1:0] i_load_custom;
  logic                i_clear, i_start;
  logic                o_busy, o_done;
  logic [ID_W-1:0]     i_rd_addr;
  logic [CUSTOM_W-1:0] o_rd_custom;
  logic                o_error;
  logic [ID_W-1:0]     o_reads_served, o_writes_accepted;

  int checks   = 0;
  int failures = 0;

  ext_point_server_if ext ();

  ext_point_server #(.DEPTH(DEPTH)) dut (
    .i_SYSTEM_clk      (i_SYSTEM_clk),
    .i_SYSTEM_rst      (i_SYSTEM_rst),
    .i_load_valid      (i_load_valid),
    .o_load_ready      (o_load_ready),
    .i_load_x          (i_load_x),
    .i_load_y          (i_load_y),
    .i_load_z          (i_load_z),
    .i_load_custom     (i_load_custom),
    .i_clear           (i_clear),
    .i_start           (i_start),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .i_rd_addr         (i_rd_addr),
    .o_rd_custom       (o_rd_custom),
    .o_error           (o_error),
    .o_reads_served    (o_reads_served),
    .o_writes_accepted (o_writes_accepted),
    .ext               (ext)
  );

  always #5 i_SYSTEM_clk = ~i_SYSTEM_clk;

  // Advance one clock; inputs set before the call are sampled at that edge.
  task automatic tick();
    @(posedge i_SYSTEM_clk);
    #1;
  endtask

  task automatic test_reset();
    i_SYSTEM_rst = 1'b0;
    tick();
    tick();
    i_SYSTEM_rst = 1'b1;
    checks++; if (o_load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got %b exp 1", o_load_ready); end
    checks++; if ({o_busy, o_done, o_error} !== 3'b000) begin failures++; $display("FAIL reset_status got %b exp 000", {o_busy, o_done, o_error}); end
    checks++; if ({ext.EXT_enable, ext.EXT_readValid, ext.EXT_writeReady} !== 3'b000) begin failures++; $display("FAIL reset_ext_ctrl got %b exp 000", {ext.EXT_enable, ext.EXT_readValid, ext.EXT_writeReady}); end
    checks++; if ({ext.EXT_PCSize, o_reads_served, o_writes_accepted} !== 57'd0) begin failures++; $display("FAIL reset_counters got %h exp 0", {ext.EXT_PCSize, o_reads_served, o_writes_accepted}); end
    checks++; if ({ext.EXT_pointX, ext.EXT_pointY, o_rd_custom} !== 48'd0) begin failures++; $display("FAIL reset_data got %h exp 0", {ext.EXT_pointX, ext.EXT_pointY, o_rd_custom}); end
  endtask

  // Four points: x = 1..4, y = -1..-4, z = 0, custom = 0.
  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      i_load_valid  = 1'b1;
      i_load_x      = 16'(i + 1);
      i_load_y      = 16'(-(i + 1));
      i_load_z      = 16'h0;
      i_load_custom = 16'h0;
      tick();
    end
    i_load_valid = 1'b0;
    checks++; if (o_load_ready !== 1'b1) begin failures++; $display("FAIL load_ready_after4 got %b exp 1", o_load_ready); end
  endtask

  task automatic test_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if ({ext.EXT_enable, o_busy, o_load_ready} !== 3'b110) begin failures++; $display("FAIL start_status got %b exp 110", {ext.EXT_enable, o_busy, o_load_ready}); end
    checks++; if (ext.EXT_PCSize !== 19'd4) begin failures++; $display("FAIL start_pcsize got %0d exp 4", ext.EXT_PCSize); end
  endtask

  // Read ID 2 with readReady held one cycle past the handshake.
  task automatic test_read();
    int vcount = 0;
    ext.EXT_readReady = 1'b1;
    ext.EXT_readID    = 19'd2;
    tick();
    checks++; if (ext.EXT_readValid !== 1'b0) begin failures++; $display("FAIL read_latency_t1 got %b exp 0", ext.EXT_readValid); end
    tick();
    if (ext.EXT_readValid) vcount++;
    checks++; if (ext.EXT_readValid !== 1'b1) begin failures++; $display("FAIL read_valid_t2 got %b exp 1", ext.EXT_readValid); end
    checks++; if (ext.EXT_pointX !== 16'd3) begin failures++; $display("FAIL read_x got %h exp 0003", ext.EXT_pointX); end
    checks++; if (ext.EXT_pointY !== 16'hFFFD) begin failures++; $display("FAIL read_y got %h exp fffd", ext.EXT_pointY); end
    checks++; if ({ext.EXT_pointZ, ext.EXT_readCustomField} !== 32'd0) begin failures++; $display("FAIL read_zc got %h exp 0", {ext.EXT_pointZ, ext.EXT_readCustomField}); end
    tick();
    if (ext.EXT_readValid) vcount++;
    checks++; if (o_reads_served !== 19'd1) begin failures++; $display("FAIL read_served got %0d exp 1", o_reads_served); end
    tick();
    if (ext.EXT_readValid) vcount++;
    ext.EXT_readReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ext.EXT_readValid) vcount++;
    end
    checks++; if (vcount !== 1) begin failures++; $display("FAIL read_single_valid got %0d exp 1", vcount); end
    checks++; if (o_reads_served !== 19'd1) begin failures++; $display("FAIL read_served_after_hold got %0d exp 1", o_reads_served); end
  endtask

  // Write ID 1 with writeValid held two cycles: exactly one writeReady pulse.
  task automatic test_write();
    int pcount = 0;
    ext.EXT_writeValid       = 1'b1;
    ext.EXT_writeID          = 19'd1;
    ext.EXT_writeCustomField = 16'h0002;
    tick();
    checks++; if (ext.EXT_writeReady !== 1'b1) begin failures++; $display("FAIL write_ready_t1 got %b exp 1", ext.EXT_writeReady); end
    if (ext.EXT_writeReady) pcount++;
    tick();
    if (ext.EXT_writeReady) pcount++;
    ext.EXT_writeValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ext.EXT_writeReady) pcount++;
    end
    checks++; if (pcount !== 1) begin failures++; $display("FAIL write_single_pulse got %0d exp 1", pcount); end
    checks++; if (o_writes_accepted !== 19'd1) begin failures++; $display("FAIL write_accepted got %0d exp 1", o_writes_accepted); end
    checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL write_no_error got %b exp 0", o_error); end
  endtask

  // readID 4 with PCSize 4 is out of range: zero data and error.
  task automatic test_oob_read();
    ext.EXT_readReady = 1'b1;
    ext.EXT_readID    = 19'd4;
    tick();
    tick();
    checks++; if (ext.EXT_readValid !== 1'b1) begin failures++; $display("FAIL oob_valid got %b exp 1", ext.EXT_readValid); end
    checks++; if ({ext.EXT_pointX, ext.EXT_pointY, ext.EXT_pointZ, ext.EXT_readCustomField} !== 64'd0) begin failures++; $display("FAIL oob_data got %h exp 0", {ext.EXT_pointX, ext.EXT_pointY, ext.EXT_pointZ, ext.EXT_readCustomField}); end
    checks++; if (o_error !== 1'b1) begin failures++; $display("FAIL oob_error got %b exp 1", o_error); end
    tick();
    ext.EXT_readReady = 1'b0;
    tick();
    checks++; if (o_reads_served !== 19'd2) begin failures++; $display("FAIL oob_served got %0d exp 2", o_reads_served); end
  endtask

  task automatic test_done();
    ext.EXT_doneProcessing = 1'b1;
    tick();
    ext.EXT_doneProcessing = 1'b0;
    checks++; if ({o_done, o_busy, ext.EXT_enable} !== 3'b110) begin failures++; $display("FAIL done_state got %b exp 110", {o_done, o_busy, ext.EXT_enable}); end
    tick();
    checks++; if ({o_done, o_busy, o_load_ready} !== 3'b001) begin failures++; $display("FAIL done_to_idle got %b exp 001", {o_done, o_busy, o_load_ready}); end
  endtask

  task automatic test_readback();
    i_rd_addr = 19'd1;
    tick();
    checks++; if (o_rd_custom !== 16'h0002) begin failures++; $display("FAIL readback_addr1 got %h exp 0002", o_rd_custom); end
    i_rd_addr = 19'd0;
    tick();
    checks++; if (o_rd_custom !== 16'h0000) begin failures++; $display("FAIL readback_addr0 got %h exp 0000", o_rd_custom); end
  endtask

  task automatic test_clear();
    checks++; if (o_error !== 1'b1) begin failures++; $display("FAIL clear_pre_error got %b exp 1", o_error); end
    i_clear = 1'b1;
    i_start = 1'b1;
    tick();
    i_clear = 1'b0;
    i_start = 1'b0;
    checks++; if ({o_error, o_busy} !== 2'b00) begin failures++; $display("FAIL clear_error_busy got %b exp 00", {o_error, o_busy}); end
  endtask

  // Fill all DEPTH entries, then one more load that must be dropped.
  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      i_load_valid  = 1'b1;
      i_load_x      = 16'(i);
      i_load_y      = 16'h0;
      i_load_z      = 16'h0;
      i_load_custom = 16'hA000 + 16'(i);
      tick();
      if (i == DEPTH - 2) begin
        checks++; if (o_load_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_before_full got %b exp 1", o_load_ready); end
      end
    end
    checks++; if ({o_load_ready, o_error} !== 2'b00) begin failures++; $display("FAIL ovf_full got %b exp 00", {o_load_ready, o_error}); end
    i_load_custom = 16'hBEEF;
    tick();
    i_load_valid = 1'b0;
    checks++; if ({o_load_ready, o_error} !== 2'b01) begin failures++; $display("FAIL ovf_dropped got %b exp 01", {o_load_ready, o_error}); end
    i_rd_addr = 19'd2047;
    tick();
    checks++; if (o_rd_custom !== 16'hA7FF) begin failures++; $display("FAIL ovf_readback_last got %h exp a7ff", o_rd_custom); end
    i_rd_addr = 19'd0;
    tick();
    checks++; if (o_rd_custom !== 16'hA000) begin failures++; $display("FAIL ovf_readback_first got %h exp a000", o_rd_custom); end
  endtask

  // Reset while readValid and writeReady are high, then rerun on the cleared count.
  task automatic test_reset_mid_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (ext.EXT_PCSize !== 19'd2048) begin failures++; $display("FAIL mid_pcsize got %0d exp 2048", ext.EXT_PCSize); end
    ext.EXT_readReady = 1'b1;
    ext.EXT_readID    = 19'd5;
    tick();
    ext.EXT_readReady = 1'b0;
    tick();
    checks++; if ({ext.EXT_readValid, ext.EXT_pointX} !== {1'b1, 16'd5}) begin failures++; $display("FAIL mid_read got %h exp 10005", {ext.EXT_readValid, ext.EXT_pointX}); end
    ext.EXT_writeValid       = 1'b1;
    ext.EXT_writeID          = 19'd7;
    ext.EXT_writeCustomField = 16'h1234;
    tick();
    checks++; if ({ext.EXT_readValid, ext.EXT_writeReady} !== 2'b11) begin failures++; $display("FAIL mid_pre_reset got %b exp 11", {ext.EXT_readValid, ext.EXT_writeReady}); end
    i_SYSTEM_rst       = 1'b0;
    ext.EXT_writeValid = 1'b0;
    tick();
    i_SYSTEM_rst = 1'b1;
    checks++; if ({ext.EXT_enable, ext.EXT_readValid, ext.EXT_writeReady, o_busy} !== 4'b0000) begin failures++; $display("FAIL mid_reset_ext got %b exp 0000", {ext.EXT_enable, ext.EXT_readValid, ext.EXT_writeReady, o_busy}); end
    checks++; if ({o_load_ready, o_error, ext.EXT_pointX} !== {1'b1, 1'b0, 16'd0}) begin failures++; $display("FAIL mid_reset_idle got %h exp 20000", {o_load_ready, o_error, ext.EXT_pointX}); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if ({ext.EXT_enable, ext.EXT_PCSize} !== {1'b1, 19'd0}) begin failures++; $display("FAIL rerun_empty got %h exp 80000", {ext.EXT_enable, ext.EXT_PCSize}); end
    ext.EXT_doneProcessing = 1'b1;
    tick();
    ext.EXT_doneProcessing = 1'b0;
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL rerun_done got %b exp 1", o_done); end
    tick();
    checks++; if ({o_done, o_busy} !== 2'b00) begin failures++; $display("FAIL rerun_idle got %b exp 00", {o_done, o_busy}); end
  endtask

  initial begin
    i_SYSTEM_rst             = 1'b0;
    i_load_valid             = 1'b0;
    i_load_x                 = '0;
    i_load_y                 = '0;
    i_load_z                 = '0;
    i_load_custom            = '0;
    i_clear                  = 1'b0;
    i_start                  = 1'b0;
    i_rd_addr                = '0;
    ext.EXT_readReady        = 1'b0;
    ext.EXT_readID           = '0;
    ext.EXT_writeValid       = 1'b0;
    ext.EXT_writeID          = '0;
    ext.EXT_writeCustomField = '0;
    ext.EXT_doneProcessing   = 1'b0;

    test_reset();
    test_load();
    test_start();
    test_read();
    test_write();
    test_oob_read();
    test_done();
    test_readback();
    test_clear();
    test_overflow();
    test_reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_point_server.md
# ext_point_server

Core-side responder for the ALFA extension interface: holds a point cloud in on-chip RAM and serves extension point reads and custom-field writes. The host loads points in IDLE, pulses start, and the block serves the extension until the extension raises `EXT_doneProcessing`. Results are then read back through a host port. It sits between the host/DMA loader and any extension module.

## Interface

- `DEPTH`, 2048, point RAM entries; `EXT_PCSize` never exceeds this.
- `i_SYSTEM_clk`  in  1  single clock.
- `i_SYSTEM_rst`  in  1  reset, synchronous, active-low (0 = reset).
- `i_load_valid`/`o_load_ready`  in/out  1  host point-load handshake.
- `i_load_x`/`i_load_y`/`i_load_z`  in  16 each  signed point coordinates.
- `i_load_custom`  in  16  initial custom field.
- `i_clear`  in  1  IDLE only; zeroes the load count.
- `i_start`  in  1  IDLE only; begins a run.
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  one-cycle pulse when a run completes.
- `i_rd_addr`  in  19  host readback address (IDLE only).
- `o_rd_custom`  out  16  custom field at `i_rd_addr`, one cycle later.
- `o_error`  out  1  sticky; set on any out-of-range ID or load overflow; cleared by `i_clear`.
- `o_reads_served`/`o_writes_accepted`  out  19 each  per-run counters.
- Extension side: `EXT_enable` out 1; `EXT_PCSize` out 19; `EXT_readReady` in 1; `EXT_readID` in 19; `EXT_readValid` out 1; `EXT_pointX/Y/Z` out 16 each; `EXT_readCustomField` out 16; `EXT_writeValid` in 1; `EXT_writeID` in 19; `EXT_writeCustomField` in 16; `EXT_writeReady` out 1; `EXT_doneProcessing` in 1.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `o_load_ready` = 1 while load count < DEPTH. Each load handshake writes {x,y,z,custom} at the load count, then increments it.
  - A load attempt at count == DEPTH is dropped and sets `o_error`.
  - `i_start` → RUN. `EXT_PCSize` is latched from the load count and both per-run counters are zeroed.
  - `i_clear` has priority over a same-cycle `i_start`.
- RUN: `EXT_enable` = 1, `o_load_ready` = 0, host readback ignored.
  - Read responder, armed:
    - `EXT_readReady` = 1 → sample `EXT_readID`, issue the RAM read, disarm.
    - The RAM read has one cycle of latency. The point and custom field are registered onto `EXT_*` outputs, and `EXT_readValid` asserts.
    - `EXT_readValid` holds until the cycle `EXT_readReady` && `EXT_readValid` is true, then drops the next cycle. That handshake increments `o_reads_served`.
    - Re-arm only after `EXT_readReady` is sampled low. The extension holds readReady one extra cycle after the handshake; that cycle must not trigger a second read.
    - readID ≥ `EXT_PCSize` → respond with all-zero data and set `o_error`.
  - Write responder, armed:
    - `EXT_writeValid` = 1 → next cycle `EXT_writeReady` pulses for exactly one cycle.
    - On that pulse, the RAM custom field at `EXT_writeID` is overwritten; coordinates are preserved via read-modify-free split storage. `o_writes_accepted` increments.
    - Re-arm only after `EXT_writeValid` is sampled low.
    - writeID ≥ `EXT_PCSize` → `EXT_writeReady` still pulses, the RAM is not written, and `o_error` is set.
  - `EXT_doneProcessing` = 1 → DONE. An in-flight write pulse in the same cycle still completes.
- DONE: `EXT_enable` = 0; `o_done` pulses; → IDLE next cycle. RAM and load count are retained, so a re-run is possible without reloading.
- Extension reads and writes may overlap. The RAM's independent ports serve both without stalls.

## Timing

- Reset (`i_SYSTEM_rst` = 0):
  - State → IDLE; load count = 0.
  - All outputs = 0, except `o_load_ready`, which is 1 on the first cycle after reset.
  - RAM contents are not cleared.
  - Reset mid-RUN aborts immediately: `EXT_enable`, `EXT_readValid`, and `EXT_writeReady` are 0 the next cycle.
- Read latency: readReady sampled high at cycle t → `EXT_readValid` high at t+2.
- Write latency: writeValid sampled high at t → `EXT_writeReady` high at t+1 only. Readback of that field is possible from t+2.
- Host readback: `i_rd_addr` at t → `o_rd_custom` valid at t+1.
- `EXT_PCSize` = 0: the run is legal; the extension completes immediately.

## Structure

- Shared package `alfa_ext_pkg`:
  - State encodings.
  - ID width (19), coordinate and custom widths (16).
  - Point-word struct {x, y, z, custom}.
- Sub-module `ext_point_ram`:
  - DEPTH entries.
  - Port A: write, with separate byte-lane enables for the coordinate and custom-field sections.
  - Port B: synchronous read, one-cycle latency.
- Port arbitration:
  - Port A serves loads in IDLE and extension writes in RUN.
  - Port B serves host readback in IDLE and extension reads in RUN.

## Test plan

- Load 4 points (x = 1..4, y = −1..−4, z = 0, custom = 0), start; the extension reads ID 2 → at t+2 `EXT_pointX` = 3, `EXT_pointY` = 0xFFFD, `EXT_readValid` = 1; `o_reads_served` = 1.
- The extension holds readReady one cycle past the handshake → exactly one read and one readValid assertion.
- Write ID 1, custom = 0x0002, with writeValid held 2 cycles → a single `EXT_writeReady` pulse; after done, readback at addr 1 gives 0x0002 and addr 0 gives 0.
- readID = 4 with PCSize = 4 → zero data returned, `o_error` = 1; `i_clear` → `o_error` = 0.
- Load DEPTH+1 points → the last load is dropped, `o_load_ready` = 0, `o_error` = 1.
- Reset asserted mid-RUN with readValid high → next cycle all EXT outputs are 0 and state is IDLE; a subsequent start reruns on the retained count of 0.
